// File: rtl/switch_top.sv
// Single-ingress, four-egress byte switch: frames are routed by their first byte (DA)
// to every egress FIFO whose configured address matches. Optional macro: SWITCH_BROADCAST_EN.

module switch_top #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_enable_in,
    input  logic [7:0] data_in,
    output logic       read_out,
    output logic [7:0] port_out [4],
    output logic       port_ready [4],
    input  logic       port_read [4],
    input  logic       mem_sel_en,
    input  logic       mem_wr_rd_s,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_wr_data,
    output logic [7:0] mem_rd_data,
    output logic       mem_ack
);

    // state    | meaning
    // ST_IDLE  | between frames; next valid byte is a DA
    // ST_FRAME | inside a frame; bytes follow the latched dest mask

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_t;

    frame_state_t   state;
    logic [3:0]     mask_q;
    logic [3:0]     match;
    logic [3:0]     dest_mask;
    logic [3:0]     push;
    logic [3:0]     pop;
    logic [3:0]     full;
    logic [3:0]     empty;

    logic [7:0]     port_addr [4];
    logic [7:0]     fifo_mem  [4][FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr    [4];
    logic [PW-1:0]  rd_ptr    [4];
    logic [CW-1:0]  count     [4];

    // Config register bank; ack is issued for every sampled access, mapped or not.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                port_addr[i] <= 8'h00;
            end
            mem_ack     <= 1'b0;
            mem_rd_data <= 8'h00;
        end else begin
            mem_ack <= mem_sel_en;
            if (mem_sel_en) begin
                if (mem_wr_rd_s) begin
                    if (mem_addr < 8'd4) begin
                        port_addr[mem_addr[1:0]] <= mem_wr_data;
                    end
                end else begin
                    mem_rd_data <= (mem_addr < 8'd4) ? port_addr[mem_addr[1:0]] : 8'h00;
                end
            end
        end
    end

    always_comb begin
        match = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            match[i] = (port_addr[i] == data_in);
        end
`ifdef SWITCH_BROADCAST_EN
        if (data_in == 8'hFF) begin
            match = 4'b1111;
        end
`endif
    end

    // The DA cycle routes on the live compare; later bytes use the latched mask.
    always_comb begin
        dest_mask = 4'b0000;
        if (sw_enable_in) begin
            dest_mask = (state == ST_IDLE) ? match : mask_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= ST_IDLE;
            mask_q <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sw_enable_in) begin
                        state  <= ST_FRAME;
                        mask_q <= match;
                    end
                end
                ST_FRAME: begin
                    if (!sw_enable_in) begin
                        state  <= ST_IDLE;
                        mask_q <= 4'b0000;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mask_q <= 4'b0000;
                end
            endcase
        end
    end

    // A full FIFO still accepts a byte when it is popped in the same cycle.
    always_comb begin
        full  = 4'b0000;
        empty = 4'b0000;
        push  = 4'b0000;
        pop   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
            pop[i]   = port_read[i] && !empty[i];
            push[i]  = dest_mask[i] && (!full[i] || pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            port_ready[i] = !empty[i];
            port_out[i]   = empty[i] ? 8'h00 : fifo_mem[i][rd_ptr[i]];
        end
    end

    assign read_out = !rst_n && !(|full);

endmodule

// File: tb/tb_switch_top.sv
// Directed vector bench for switch_top: table of single-cycle vectors plus
// hand-written sequences for FIFO-full and asynchronous reset.

module tb_switch_top;

    logic       clk;
    logic       rst_n;
    logic       sw_enable_in;
    logic [7:0] data_in;
    logic       read_out;
    logic [7:0] port_out [4];
    logic       port_ready [4];
    logic       port_read [4];
    logic       mem_sel_en;
    logic       mem_wr_rd_s;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       mem_ack;

    int n_vec = 0;
    int n_err = 0;

`ifdef SWITCH_BROADCAST_EN
    localparam logic BC = 1'b1;
`else
    localparam logic BC = 1'b0;
`endif

    switch_top #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_enable_in (sw_enable_in),
        .data_in      (data_in),
        .read_out     (read_out),
        .port_out     (port_out),
        .port_ready   (port_ready),
        .port_read    (port_read),
        .mem_sel_en   (mem_sel_en),
        .mem_wr_rd_s  (mem_wr_rd_s),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  din;
        logic [3:0]  rd;
        logic        sel;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic        ro;
        logic [3:0]  rdy;
        logic [31:0] outs;
        logic        ack;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(input logic en, input logic [7:0] din, input logic [3:0] rd,
                                input logic sel, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wd, input logic ro, input logic [3:0] rdy,
                                input logic [31:0] outs, input logic ack, input logic [7:0] rdata);
        vec_t v;
        v.en = en; v.din = din; v.rd = rd; v.sel = sel; v.wr = wr; v.addr = addr; v.wd = wd;
        v.ro = ro; v.rdy = rdy; v.outs = outs; v.ack = ack; v.rdata = rdata;
        return v;
    endfunction

    function automatic logic [3:0] rdy_vec();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = port_ready[i];
        return r;
    endfunction

    function automatic logic [31:0] out_vec();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = port_out[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] din, input logic [3:0] rd,
                         input logic sel, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        sw_enable_in = en;
        data_in      = din;
        for (int i = 0; i < 4; i++) port_read[i] = rd[i];
        mem_sel_en   = sel;
        mem_wr_rd_s  = wr;
        mem_addr     = addr;
        mem_wr_data  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] heads [7];

    initial begin
        heads[0] = 8'h03; heads[1] = 8'h04; heads[2] = 8'h05; heads[3] = 8'h06;
        heads[4] = 8'h07; heads[5] = 8'h0A; heads[6] = 8'h00;

        tbl[0]  = mk(0, 8'h00, 4'b0000, 1, 1, 8'h00, 8'h44, 1, 4'b0000, 32'h0, 1, 8'h00);
        tbl[1]  = mk(0, 8'h00, 4'b0000, 1, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 1, 8'h44);
        tbl[2]  = mk(0, 8'h00, 4'b0000, 1, 0, 8'h10, 8'h00, 1, 4'b0000, 32'h0, 1, 8'h00);
        tbl[3]  = mk(0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h00);
        tbl[4]  = mk(0, 8'h00, 4'b0000, 1, 1, 8'h01, 8'h01, 1, 4'b0000, 32'h0, 1, 8'h00);
        tbl[5]  = mk(0, 8'h00, 4'b0000, 1, 1, 8'h02, 8'h01, 1, 4'b0000, 32'h0, 1, 8'h00);
        tbl[6]  = mk(0, 8'h00, 4'b0000, 1, 1, 8'h03, 8'h01, 1, 4'b0000, 32'h0, 1, 8'h00);
        tbl[7]  = mk(0, 8'h00, 4'b0000, 1, 0, 8'h02, 8'h00, 1, 4'b0000, 32'h0, 1, 8'h01);
        tbl[8]  = mk(1, 8'h44, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0001, 32'h44, 0, 8'h01);
        tbl[9]  = mk(1, 8'h44, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0001, 32'h44, 0, 8'h01);
        tbl[10] = mk(0, 8'h00, 4'b0001, 0, 0, 8'h00, 8'h00, 1, 4'b0001, 32'h44, 0, 8'h01);
        tbl[11] = mk(0, 8'h00, 4'b0001, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[12] = mk(0, 8'h00, 4'b0000, 1, 1, 8'h00, 8'h01, 1, 4'b0000, 32'h0, 1, 8'h01);
        tbl[13] = mk(1, 8'h55, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[14] = mk(1, 8'hAA, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[15] = mk(0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[16] = mk(0, 8'h00, 4'b0000, 1, 1, 8'h01, 8'h22, 1, 4'b0000, 32'h0, 1, 8'h01);
        tbl[17] = mk(0, 8'h00, 4'b0000, 1, 1, 8'h03, 8'h22, 1, 4'b0000, 32'h0, 1, 8'h01);
        tbl[18] = mk(1, 8'h22, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b1010, 32'h22002200, 0, 8'h01);
        tbl[19] = mk(1, 8'h33, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b1010, 32'h22002200, 0, 8'h01);
        tbl[20] = mk(1, 8'h44, 4'b0000, 0, 0, 8'h00, 8'h00, 1, 4'b1010, 32'h22002200, 0, 8'h01);
        tbl[21] = mk(0, 8'h00, 4'b1010, 0, 0, 8'h00, 8'h00, 1, 4'b1010, 32'h33003300, 0, 8'h01);
        tbl[22] = mk(0, 8'h00, 4'b1010, 0, 0, 8'h00, 8'h00, 1, 4'b1010, 32'h44004400, 0, 8'h01);
        tbl[23] = mk(0, 8'h00, 4'b1010, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[24] = mk(0, 8'h00, 4'b1111, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[25] = mk(1, 8'hFF, 4'b0000, 0, 0, 8'h00, 8'h00, 1, {4{BC}}, {32{BC}}, 0, 8'h01);
        tbl[26] = mk(0, 8'h00, 4'b1111, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);
        tbl[27] = mk(1, 8'h01, 4'b0000, 1, 1, 8'h00, 8'h77, 1, 4'b0101, 32'h00010001, 1, 8'h01);
        tbl[28] = mk(0, 8'h00, 4'b0101, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 32'h0, 0, 8'h01);

        // Reset state
        rst_n = 1'b1;
        drive(0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00);
        step();
        step();
        check("rst_read_out", {31'b0, read_out}, 32'h0);
        check("rst_port_ready", {28'b0, rdy_vec()}, 32'h0);
        check("rst_port_out", out_vec(), 32'h0);
        check("rst_mem_ack", {31'b0, mem_ack}, 32'h0);
        check("rst_mem_rd_data", {24'b0, mem_rd_data}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("post_rst_read_out", {31'b0, read_out}, 32'h1);

        // Table-driven single-cycle vectors
        for (int k = 0; k < 29; k++) begin
            drive(tbl[k].en, tbl[k].din, tbl[k].rd, tbl[k].sel, tbl[k].wr, tbl[k].addr, tbl[k].wd);
            step();
            check($sformatf("v%0d_read_out", k), {31'b0, read_out}, {31'b0, tbl[k].ro});
            check($sformatf("v%0d_port_ready", k), {28'b0, rdy_vec()}, {28'b0, tbl[k].rdy});
            check($sformatf("v%0d_port_out", k), out_vec(), tbl[k].outs);
            check($sformatf("v%0d_mem_ack", k), {31'b0, mem_ack}, {31'b0, tbl[k].ack});
            check($sformatf("v%0d_mem_rd_data", k), {24'b0, mem_rd_data}, {24'b0, tbl[k].rdata});
        end

        // FIFO full: 10-byte frame to port 0 (address 0x77), no reads
        for (int k = 0; k < 10; k++) begin
            drive(1, (k == 0) ? 8'h77 : 8'(k), 4'b0000, 0, 0, 8'h00, 8'h00);
            step();
            check($sformatf("full%0d_read_out", k), {31'b0, read_out}, (k + 1 < 8) ? 32'h1 : 32'h0);
            check($sformatf("full%0d_port_ready", k), {28'b0, rdy_vec()}, 32'h1);
            check($sformatf("full%0d_head", k), {24'b0, port_out[0]}, 32'h77);
        end
        // push and pop while full: count stays at 8
        drive(1, 8'h0A, 4'b0001, 0, 0, 8'h00, 8'h00);
        step();
        check("fullpp_read_out", {31'b0, read_out}, 32'h0);
        check("fullpp_head", {24'b0, port_out[0]}, 32'h01);
        drive(0, 8'h00, 4'b0001, 0, 0, 8'h00, 8'h00);
        step();
        check("pop_read_out", {31'b0, read_out}, 32'h1);
        check("pop_head", {24'b0, port_out[0]}, 32'h02);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("drain%0d_head", k), {24'b0, port_out[0]}, {24'b0, heads[k]});
        end
        check("drain_port_ready", {28'b0, rdy_vec()}, 32'h0);

        // Asynchronous reset mid-frame and mid-access
        drive(1, 8'h77, 4'b0000, 0, 0, 8'h00, 8'h00);
        step();
        drive(1, 8'h12, 4'b0000, 1, 1, 8'h01, 8'h99);
        step();
        check("pre_rst_port_ready", {28'b0, rdy_vec()}, 32'h1);
        check("pre_rst_mem_ack", {31'b0, mem_ack}, 32'h1);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst_port_ready", {28'b0, rdy_vec()}, 32'h0);
        check("async_rst_port_out", out_vec(), 32'h0);
        check("async_rst_mem_ack", {31'b0, mem_ack}, 32'h0);
        check("async_rst_read_out", {31'b0, read_out}, 32'h0);
        drive(0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00);
        step();
        rst_n = 1'b0;
        drive(0, 8'h00, 4'b0000, 1, 0, 8'h00, 8'h00);
        step();
        check("rst_addr0", {24'b0, mem_rd_data}, 32'h00);
        drive(0, 8'h00, 4'b0000, 1, 0, 8'h01, 8'h00);
        step();
        check("rst_addr1", {24'b0, mem_rd_data}, 32'h00);
        drive(1, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00);
        step();
        check("rst_route_all", {28'b0, rdy_vec()}, 32'hF);
        drive(0, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switch_top.md
Name: switch_top

Overview:
- Single-input, 4-output packet switch with a byte-wide ingress stream and four byte-wide egress ports.
- A frame's first byte is its destination address (DA). Every byte of the frame is copied into the FIFO of each port whose configured address equals DA.
- Port addresses live in a small register bank written and read over a simple memory-mapped config interface.
- Sits between an upstream byte source and four downstream consumers.

Parameters:
- FIFO_DEPTH, 8, entries per egress FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high: asserted when 1 (name kept per codebase despite the suffix).
- sw_enable_in  in  1  ingress byte valid; a frame is a run of consecutive cycles with it high.
- data_in  in  8  ingress byte.
- read_out  out  1  switch can accept ingress bytes.
- port_out  out  8 x [4]  unpacked array; head byte of each egress FIFO.
- port_ready  out  1 x [4]  unpacked array; egress FIFO non-empty.
- port_read  in  1 x [4]  unpacked array; pop request per port.
- mem_sel_en  in  1  config access strobe.
- mem_wr_rd_s  in  1  1 = write, 0 = read.
- mem_addr  in  8  config address.
- mem_wr_data  in  8  config write data.
- mem_rd_data  out  8  config read data.
- mem_ack  out  1  config access acknowledge.

Behaviour:
- Reset (async, rst_n=1):
  - Port address regs 0..3 = 8'h00; FIFOs emptied; frame state idle.
  - mem_ack=0, mem_rd_data=0, port_ready=0, port_out=0, read_out=0.
- Config registers:
  - Addresses 0..3 = port address of ports 0..3. All other addresses: writes ignored, reads return 8'h00.
  - Each cycle with mem_sel_en=1 performs one access; mem_sel_en held high gives one access per cycle.
  - Writes update the register at the clock edge.
  - mem_ack is registered: high exactly the cycle after each sampled access, for every address including unmapped ones.
  - On a read, mem_rd_data is valid in the ack cycle and holds its value until the next read.
- Ingress frame logic:
  - Idle and sw_enable_in=1: the cycle is frame start. Dest mask = per-port (portaddr[i] == data_in), using register values before any same-cycle config write.
  - Mask is latched and held for the whole frame.
  - Every valid byte of the frame, including DA, is pushed into each masked FIFO in its own cycle. The first byte uses the combinational mask.
  - sw_enable_in=0 returns to idle. A new frame needs at least one idle cycle.
  - Mask all-zero: frame silently discarded.
- read_out:
  - 1 when out of reset and no FIFO is full.
  - A byte aimed at a full FIFO is dropped for that port only; other masked ports still receive it.
- Egress (per port, show-ahead FIFO):
  - port_ready[i] = !empty; port_out[i] = head byte, 8'h00 when empty.
  - port_read[i]=1 while ready pops at the clock edge; while empty it is ignored.
  - Push and pop in the same cycle are both honoured; count unchanged, even when full.
  - A byte pushed at edge N is visible (port_ready=1) after edge N.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an occupancy count.
- Reset mid-frame or mid-access: everything is cleared immediately. The frame is abandoned; no ack is issued for the interrupted access.

Optional Feature:
- Macro SWITCH_BROADCAST_EN.
  - Defined: DA == 8'hFF selects all four ports regardless of configured addresses, OR'd with normal matches.
  - Undefined: 8'hFF is an ordinary address, matched only by equality.

Test Plan:
- Config: after reset, write addr 0x00 = 0x44 -> mem_ack=1 next cycle only. Read addr 0x00 -> mem_ack=1 with mem_rd_data=0x44. Read addr 0x10 -> ack with 0x00.
- Routing: port0=0x44, ports1-3=0x01; send 2-byte frame 0x44,0x44 -> only port_ready[0] rises the cycle after the first byte, port_out[0]=0x44. Two pops with port_read[0] -> port_ready[0]=0.
- Miss: all ports configured 0x01; frame 0x55,0xAA -> no port_ready asserts; read_out stays 1.
- Multicast: ports 1 and 3 = 0x22; frame 0x22,0x33,0x44 -> ports 1 and 3 each output 0x22,0x33,0x44 in order.
- Full: frame of FIFO_DEPTH+2 bytes to port 0 with no reads -> read_out falls once 8 stored. Extra bytes dropped; a pop restores read_out=1. Simultaneous push/pop while full keeps count at 8.
- Reset: assert rst_n=1 mid-frame with data queued -> port_ready=0, mem_ack=0, port addresses back to 0x00 immediately (asynchronous).
